// File: rtl/btn_pkg.sv
// =============================================================================
// Module      : btn_pkg
// Description : Shared channel-state encoding and default debounce constants
//               for button_conditioner.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

package btn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_HELD         = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } btn_state_t;

    localparam int DB_CYCLES_DEF = 50000;
    localparam int CNT_W_DEF     = 16;

endpackage : btn_pkg

`default_nettype wire

// File: rtl/btn_debounce.sv
// =============================================================================
// Module      : btn_debounce
// Description : One button channel: 2-flop synchroniser, debounce FSM with
//               saturating counter, single-cycle press request.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module btn_debounce
    import btn_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEF,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_in,
    output logic press_req,
    output logic idle
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

    logic             sync_meta;
    logic             sync;
    btn_state_t       state;
    btn_state_t       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta <= 1'b0;
            sync      <= 1'b0;
            state     <= ST_IDLE;
            cnt       <= '0;
        end else begin
            sync_meta <= raw_in;
            sync      <= sync_meta;
            state     <= state_nxt;
            cnt       <= cnt_nxt;
        end
    end

    // The press request is decoded from registered state only, so the
    // top-level output flops see no path from the raw pins.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        press_req = 1'b0;
        case (state)
            ST_IDLE: begin
                if (sync) begin
                    state_nxt = ST_PRESS_WAIT;
                    cnt_nxt   = '0;
                end
            end
            ST_PRESS_WAIT: begin
                if (!sync) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_MAX) begin
                    state_nxt = ST_HELD;
                    cnt_nxt   = '0;
                    press_req = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            ST_HELD: begin
                if (!sync) begin
                    state_nxt = ST_RELEASE_WAIT;
                    cnt_nxt   = '0;
                end
            end
            ST_RELEASE_WAIT: begin
                if (sync) begin
                    state_nxt = ST_HELD;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_MAX) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign idle = (state == ST_IDLE);

endmodule : btn_debounce

`default_nettype wire

// File: rtl/button_conditioner.sv
// =============================================================================
// Module      : button_conditioner
// Description : Two debounced push-button channels merged into mutually
//               exclusive single-cycle pulses. Optional press counter is
//               enabled by defining BTN_PRESS_CNT_EN.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module button_conditioner
    import btn_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEF,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic       clk,
    input  logic       reset_n_in,
    input  logic       b0_raw_in,
    input  logic       b1_raw_in,
    output logic       b0_out,
    output logic       b1_out,
    output logic       busy_out
`ifdef BTN_PRESS_CNT_EN
    ,
    output logic [7:0] press_cnt_out
`endif
);

    logic req0;
    logic req1;
    logic idle0;
    logic idle1;
    logic pending;
    logic pending_nxt;
    logic b1_want;

    btn_debounce #(
        .DB_CYCLES (DB_CYCLES),
        .CNT_W     (CNT_W)
    ) u_ch0 (
        .clk       (clk),
        .rst_n     (reset_n_in),
        .raw_in    (b0_raw_in),
        .press_req (req0),
        .idle      (idle0)
    );

    btn_debounce #(
        .DB_CYCLES (DB_CYCLES),
        .CNT_W     (CNT_W)
    ) u_ch1 (
        .clk       (clk),
        .rst_n     (reset_n_in),
        .raw_in    (b1_raw_in),
        .press_req (req1),
        .idle      (idle1)
    );

    // b0 always wins the slot; a competing or already-pending b1 is held
    // back one cycle, and a second b1 request folds into the pending one.
    assign b1_want     = req1 | pending;
    assign pending_nxt = req0 & b1_want;

    always_ff @(posedge clk or negedge reset_n_in) begin
        if (!reset_n_in) begin
            b0_out   <= 1'b0;
            b1_out   <= 1'b0;
            pending  <= 1'b0;
            busy_out <= 1'b0;
        end else begin
            b0_out   <= req0;
            b1_out   <= b1_want & ~req0;
            pending  <= pending_nxt;
            busy_out <= ~idle0 | ~idle1 | pending_nxt;
        end
    end

`ifdef BTN_PRESS_CNT_EN
    always_ff @(posedge clk or negedge reset_n_in) begin
        if (!reset_n_in) begin
            press_cnt_out <= 8'd0;
        end else if (b0_out | b1_out) begin
            press_cnt_out <= press_cnt_out + 8'd1;
        end
    end
`endif

endmodule : button_conditioner

`default_nettype wire

// File: tb/tb_button_conditioner.sv
// =============================================================================
// Module      : tb_button_conditioner
// Description : Directed self-checking bench for button_conditioner with
//               DB_CYCLES=4 (press counter checks need BTN_PRESS_CNT_EN).
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_button_conditioner;

    localparam int DB = 4;

    logic clk = 1'b0;
    logic reset_n_in = 1'b0;
    logic b0_raw_in = 1'b0;
    logic b1_raw_in = 1'b0;
    logic b0_out;
    logic b1_out;
    logic busy_out;
`ifdef BTN_PRESS_CNT_EN
    logic [7:0] press_cnt_out;
`endif

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int n0       = 0;
    int n1       = 0;
    int nboth    = 0;
    int t0       = -1;
    int t1       = -1;
    int c_mark;
    int base0;
    int base1;

    button_conditioner #(
        .DB_CYCLES (DB),
        .CNT_W     (4)
    ) dut (
        .clk        (clk),
        .reset_n_in (reset_n_in),
        .b0_raw_in  (b0_raw_in),
        .b1_raw_in  (b1_raw_in),
        .b0_out     (b0_out),
        .b1_out     (b1_out),
        .busy_out   (busy_out)
`ifdef BTN_PRESS_CNT_EN
        ,
        .press_cnt_out (press_cnt_out)
`endif
    );

    always #5 clk = ~clk;

    // Advance one edge and sample 1ns later; record pulse activity.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (b0_out) begin n0++; t0 = cyc; end
        if (b1_out) begin n1++; t1 = cyc; end
        if (b0_out && b1_out) nboth++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset state
        ticks(3);
        chk("rst_b0", int'(b0_out), 0);
        chk("rst_b1", int'(b1_out), 0);
        chk("rst_busy", int'(busy_out), 0);
`ifdef BTN_PRESS_CNT_EN
        chk("rst_cnt", int'(press_cnt_out), 0);
`endif
        reset_n_in = 1'b1;
        ticks(3);

        // Clean press: raw sampled at edge k=c+1, pulse after edge k+6
        c_mark = cyc; base0 = n0; base1 = n1;
        b0_raw_in = 1'b1;
        ticks(10);
        chk("clean_busy_high", int'(busy_out), 1);
        ticks(10);
        b0_raw_in = 1'b0;
        ticks(12);
        chk("clean_count", n0 - base0, 1);
        chk("clean_time", t0, c_mark + 1 + DB + 2);
        chk("clean_no_b1", n1 - base1, 0);
        chk("clean_busy_low", int'(busy_out), 0);

        // Short glitches on b1: 3 high, 2 low, five times
        base1 = n1;
        for (int g = 0; g < 5; g++) begin
            b1_raw_in = 1'b1;
            ticks(3);
            b1_raw_in = 1'b0;
            ticks(2);
        end
        ticks(10);
        chk("glitch_no_b1", n1 - base1, 0);
        chk("glitch_busy_low", int'(busy_out), 0);

        // Release bounce on b0
        base0 = n0;
        b0_raw_in = 1'b1;
        ticks(10);
        b0_raw_in = 1'b0; ticks(2);
        b0_raw_in = 1'b1; ticks(1);
        b0_raw_in = 1'b0; ticks(10);
        ticks(4);
        chk("bounce_count", n0 - base0, 1);
        chk("bounce_busy_low", int'(busy_out), 0);

        // Simultaneous press
        c_mark = cyc; base0 = n0; base1 = n1; nboth = 0;
        b0_raw_in = 1'b1;
        b1_raw_in = 1'b1;
        ticks(12);
        b0_raw_in = 1'b0;
        b1_raw_in = 1'b0;
        ticks(12);
        chk("simul_b0_count", n0 - base0, 1);
        chk("simul_b1_count", n1 - base1, 1);
        chk("simul_b0_time", t0, c_mark + 1 + DB + 2);
        chk("simul_b1_time", t1, c_mark + 1 + DB + 3);
        chk("simul_never_both", nboth, 0);

        // Reset mid-count: PRESS_WAIT with cnt=2 after edge k+4
        base0 = n0;
        b0_raw_in = 1'b1;
        ticks(5);
        reset_n_in = 1'b0;
        #1;
        chk("midrst_b0", int'(b0_out), 0);
        chk("midrst_busy", int'(busy_out), 0);
        ticks(3);
        chk("midrst_b1", int'(b1_out), 0);
        chk("midrst_busy2", int'(busy_out), 0);
`ifdef BTN_PRESS_CNT_EN
        chk("midrst_cnt", int'(press_cnt_out), 0);
`endif
        reset_n_in = 1'b1;
        c_mark = cyc;
        ticks(12);
        chk("midrst_count", n0 - base0, 1);
        chk("midrst_time", t0, c_mark + 1 + DB + 2);
        b0_raw_in = 1'b0;
        ticks(12);

`ifdef BTN_PRESS_CNT_EN
        // Counter wrap: fresh reset then 257 clean presses
        reset_n_in = 1'b0;
        ticks(2);
        reset_n_in = 1'b1;
        ticks(2);
        base0 = n0;
        for (int p = 0; p < 257; p++) begin
            b0_raw_in = 1'b1;
            ticks(8);
            b0_raw_in = 1'b0;
            ticks(8);
        end
        ticks(4);
        chk("wrap_pulses", n0 - base0, 257);
        chk("wrap_cnt", int'(press_cnt_out), 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_button_conditioner

`default_nettype wire
